// File: rtl/design_rand_adder.sv
// design_rand_adder: registered WIDTH-bit unsigned adder with carry and zero flags.
// Each rising clock edge samples a and b; c, carry_o and zero_o update one cycle later.
// Optional build macro DESIGN_RAND_ADDER_SAT_EN: when defined, c saturates to all-ones
// on carry instead of wrapping. carry_o still reports the true carry.
module design_rand_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             carry_o,
  output logic             zero_o
);

  localparam int unsigned SUM_W = WIDTH + 1;

  // Reject widths outside the supported 1..32 range at elaboration
  if (WIDTH == 0 || WIDTH > 32) begin : g_width_check
    initial $fatal(1, "design_rand_adder: WIDTH=%0d outside 1..32", WIDTH);
  end

  logic [SUM_W-1:0] sum_full;
  logic [WIDTH-1:0] c_d, c_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;

  // Next-state: full-width sum, carry, result (wrap or saturate) and zero flag
  always_comb begin
    sum_full = SUM_W'(a) + SUM_W'(b);
    carry_d  = sum_full[WIDTH];
`ifdef DESIGN_RAND_ADDER_SAT_EN
    c_d      = carry_d ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    c_d      = sum_full[WIDTH-1:0];
`endif
    // Zero flag follows the value about to be registered, not the c register
    zero_d   = (c_d == '0);
  end

  // Output registers with synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      c_q     <= c_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign c       = c_q;
  assign carry_o = carry_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_design_rand_adder.sv
// Directed and random self-checking bench for design_rand_adder (WIDTH = 4).
// Build with DESIGN_RAND_ADDER_SAT_EN defined to check the saturating variant.
module tb_design_rand_adder;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] a, b;
  logic [3:0] c;
  logic       carry_o;
  logic       zero_o;

  int errors = 0;
  int checks = 0;

  design_rand_adder #(.WIDTH(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a       (a),
    .b       (b),
    .c       (c),
    .carry_o (carry_o),
    .zero_o  (zero_o)
  );

  always #5 clk_i = ~clk_i;

  // Compare all three outputs against expected values
  task automatic check(input string tag, input logic [3:0] ce, input logic carry_e,
                       input logic zero_e);
    checks++;
    assert (c === ce) else begin
      errors++;
      $error("FAIL %s c: got %0d expected %0d", tag, c, ce);
    end
    checks++;
    assert (carry_o === carry_e) else begin
      errors++;
      $error("FAIL %s carry_o: got %0b expected %0b", tag, carry_o, carry_e);
    end
    checks++;
    assert (zero_o === zero_e) else begin
      errors++;
      $error("FAIL %s zero_o: got %0b expected %0b", tag, zero_o, zero_e);
    end
  endtask

  // Apply operands before an edge, then sample 1 time unit after that edge
  task automatic step(input logic r, input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk_i);
    rst_i = r;
    a     = av;
    b     = bv;
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: 4-bit add with optional saturation
  task automatic check_model(input string tag, input logic [3:0] av, input logic [3:0] bv);
    int unsigned s;
    logic [3:0]  ce;
    logic        carry_e;
    s       = 32'(av) + 32'(bv);
    carry_e = (s > 15);
    ce      = 4'(s % 16);
`ifdef DESIGN_RAND_ADDER_SAT_EN
    if (carry_e) ce = 4'hF;
`endif
    check(tag, ce, carry_e, ce == 4'd0);
  endtask

  initial begin
    logic [3:0] ra, rb;
    rst_i = 1'b1;
    a     = 4'd5;
    b     = 4'd6;

    // Reset held for two edges with live operands
    step(1'b1, 4'd5, 4'd6);
    step(1'b1, 4'd5, 4'd6);
    check("reset", 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd5, 4'd6);
    check("post_reset", 4'd11, 1'b0, 1'b0);

    // Basic add
    step(1'b0, 4'd3, 4'd4);
    check("basic", 4'd7, 1'b0, 1'b0);

    // Overflow and exact wrap to zero
    step(1'b0, 4'd9, 4'd9);
`ifdef DESIGN_RAND_ADDER_SAT_EN
    check("overflow", 4'd15, 1'b1, 1'b0);
`else
    check("overflow", 4'd2, 1'b1, 1'b0);
`endif
    step(1'b0, 4'd15, 4'd1);
`ifdef DESIGN_RAND_ADDER_SAT_EN
    check("wrap_zero", 4'd15, 1'b1, 1'b0);
`else
    check("wrap_zero", 4'd0, 1'b1, 1'b1);
`endif
    step(1'b0, 4'd15, 4'd15);
`ifdef DESIGN_RAND_ADDER_SAT_EN
    check("max_max", 4'd15, 1'b1, 1'b0);
`else
    check("max_max", 4'd14, 1'b1, 1'b0);
`endif
    step(1'b0, 4'd15, 4'd0);
    check("max_no_carry", 4'd15, 1'b0, 1'b0);

    // Back-to-back operands
    step(1'b0, 4'd1, 4'd2);
    check("b2b_0", 4'd3, 1'b0, 1'b0);
    step(1'b0, 4'd4, 4'd9);
    check("b2b_1", 4'd13, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0);
    check("b2b_2", 4'd0, 1'b0, 1'b1);

    // Mid-stream reset in a continuous small-operand stream
    for (int i = 0; i < 12; i++) begin
      ra = 4'($urandom_range(0, 2));
      rb = 4'($urandom_range(0, 15));
      if (i == 6) begin
        step(1'b1, ra, rb);
        check("mid_reset", 4'd0, 1'b0, 1'b1);
      end else begin
        step(1'b0, ra, rb);
        check_model("mid_stream", ra, rb);
      end
    end

    // Random phase against the reference model
    for (int i = 0; i < 100; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      step(1'b0, ra, rb);
      check_model("random", ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
